// File: rtl/interrupt_controller_pkg.sv
// Shared CPU-side types: register-file and memory/ALU opcodes plus interrupt controller state.
// Also holds the default interrupt ID width used by interrupt_controller.
package interrupt_controller_pkg;

  localparam int unsigned IntcIdWidth = 4;

  typedef enum logic [1:0] {
    RegOpNone,
    RegOpRead,
    RegOpWrite,
    RegOpSwap
  } reg_op_t;

  typedef enum logic [2:0] {
    MemAluAdd,
    MemAluSub,
    MemAluAnd,
    MemAluOr,
    MemAluXor,
    MemAluLoad,
    MemAluStore,
    MemAluPass
  } memalu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StService
  } intc_state_t;

endpackage

// File: rtl/interrupt_controller_irq_sync.sv
// Single-bit two-flop synchronizer followed by a registered rising-edge pulse.
// irq_rise is high for exactly one cycle per low-to-high transition of irq_async.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_async,
  output logic irq_rise
);

  logic sync1_q, sync2_q, prev_q, rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= irq_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign irq_rise = rise_q;

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: synchronized edge capture into a pending register,
// masked arbitration (lowest index wins) and an IDLE/REQUEST/SERVICE handshake with the CPU.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned INTERRUPT_WIDTH = IntcIdWidth,
  parameter int unsigned NUM_SOURCES     = 2 ** INTERRUPT_WIDTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SOURCES-1:0]     irq_in,
  input  logic                       mask_we,
  input  logic [NUM_SOURCES-1:0]     mask_data,
  input  logic                       save_state,
  input  logic                       restore_state,
  output logic [INTERRUPT_WIDTH-1:0] interrupt,
  output logic [NUM_SOURCES-1:0]     pending,
  output logic                       busy
);

  intc_state_t                state_q;
  logic [INTERRUPT_WIDTH-1:0] id_q;
  logic                       busy_q;
  logic [NUM_SOURCES-1:0]     pending_q, pending_d;
  logic [NUM_SOURCES-1:0]     mask_q;
  logic [NUM_SOURCES-1:0]     irq_rise;
  logic [NUM_SOURCES-1:0]     served;
  logic [NUM_SOURCES-1:0]     active;
  logic [INTERRUPT_WIDTH-1:0] grant_id;
  logic                       ack;

  // Lowest set index k maps to ID k+1; ID 0 means nothing requested.
  function automatic logic [INTERRUPT_WIDTH-1:0] lowest_id(input logic [NUM_SOURCES-1:0] req);
    lowest_id = '0;
    for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
      if (req[i]) lowest_id = INTERRUPT_WIDTH'(i + 1);
    end
  endfunction

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    irq_sync u_irq_sync (
      .clk       (clk),
      .rst       (rst),
      .irq_async (irq_in[i]),
      .irq_rise  (irq_rise[i])
    );
    assign served[i] = (id_q == INTERRUPT_WIDTH'(i + 1));
  end

  always_comb begin
    ack       = (state_q == StRequest) && save_state;
    // A new edge on the served source overrides the acknowledge clear.
    pending_d = (pending_q & ~(ack ? served : '0)) | irq_rise;
    active    = pending_q & mask_q;
    grant_id  = lowest_id(active);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      id_q      <= '0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_data;
      case (state_q)
        StIdle: begin
          if (|active) begin
            id_q    <= grant_id;
            state_q <= StRequest;
          end
        end
        StRequest: begin
          if (save_state) begin
            state_q <= StService;
            busy_q  <= 1'b1;
          end
        end
        StService: begin
          if (restore_state) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            id_q    <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          id_q    <= '0;
        end
      endcase
    end
  end

  assign interrupt = id_q;
  assign pending   = pending_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a cycle-level behavioural model checked every cycle.
module tb_interrupt_controller;

  localparam int NS = 15;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] irq_in = '0;
  logic          mask_we = 1'b0;
  logic [NS-1:0] mask_data = '0;
  logic          save_state = 1'b0;
  logic          restore_state = 1'b0;
  logic [IW-1:0] interrupt;
  logic [NS-1:0] pending;
  logic          busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  interrupt_controller #(
    .INTERRUPT_WIDTH (IW),
    .NUM_SOURCES     (NS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .mask_we       (mask_we),
    .mask_data     (mask_data),
    .save_state    (save_state),
    .restore_state (restore_state),
    .interrupt     (interrupt),
    .pending       (pending),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an input sampled high at edge n (low at n-1) becomes pending at edge n+3.
  // m_st: 0 idle, 1 request, 2 service.
  logic [NS-1:0] m_hist [4];
  logic [NS-1:0] m_pend;
  logic [NS-1:0] m_mask;
  logic [NS-1:0] m_rise;
  int            m_id;
  int            m_st;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 4; k++) m_hist[k] = '0;
        m_pend = '0;
        m_mask = '0;
        m_id   = 0;
        m_st   = 0;
      end else begin
        m_rise    = m_hist[2] & ~m_hist[3];
        m_hist[3] = m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq_in;
        if (m_st == 0) begin
          for (int k = 0; k < NS; k++) begin
            if (m_st == 0 && m_pend[k] && m_mask[k]) begin
              m_id = k + 1;
              m_st = 1;
            end
          end
        end else if (m_st == 1) begin
          if (save_state) begin
            m_st = 2;
            m_pend[m_id-1] = 1'b0;
          end
        end else if (restore_state) begin
          m_st = 0;
          m_id = 0;
        end
        m_pend = m_pend | m_rise;
        if (mask_we) m_mask = mask_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("model_interrupt", 32'(interrupt), 32'(m_id));
        check("model_pending", 32'(pending), 32'(m_pend));
        check("model_busy", 32'(busy), 32'(m_st == 2));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int b);
    irq_in[b] = 1'b1;
    tick(1);
    irq_in[b] = 1'b0;
  endtask

  task automatic wmask(input logic [NS-1:0] v);
    mask_we   = 1'b1;
    mask_data = v;
    tick(1);
    mask_we   = 1'b0;
  endtask

  task automatic do_ack();
    save_state = 1'b1;
    tick(1);
    save_state = 1'b0;
  endtask

  task automatic do_ret();
    restore_state = 1'b1;
    tick(1);
    restore_state = 1'b0;
  endtask

  initial begin
    tick(2);
    check("reset_interrupt", 32'(interrupt), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    wmask(15'h7FFF);

    // Single source: latency to pending and to interrupt, then hold until acknowledge.
    pulse(2);
    tick(2);
    check("t1_pending_early", 32'(pending), 0);
    tick(1);
    check("t1_pending", 32'(pending), 32'h0004);
    check("t1_int_early", 32'(interrupt), 0);
    tick(1);
    check("t1_interrupt", 32'(interrupt), 3);
    wmask(15'h0000);
    tick(2);
    check("t1_hold_masked", 32'(interrupt), 3);
    check("t1_not_busy", 32'(busy), 0);
    wmask(15'h7FFF);
    do_ack();
    check("t1_busy", 32'(busy), 1);
    check("t1_served_clear", 32'(pending), 0);
    tick(1);
    check("t1_cpu_read", 32'(interrupt), 3);
    do_ret();
    check("t1_ret_int", 32'(interrupt), 0);
    check("t1_ret_busy", 32'(busy), 0);

    // Two simultaneous sources: lower index first, then the other.
    irq_in = 15'h0022;
    tick(1);
    irq_in = '0;
    tick(3);
    check("t2_pending", 32'(pending), 32'h0022);
    tick(1);
    check("t2_first", 32'(interrupt), 2);
    do_ack();
    check("t2_pending_left", 32'(pending), 32'h0020);
    do_ret();
    check("t2_ret_int", 32'(interrupt), 0);
    tick(1);
    check("t2_second", 32'(interrupt), 6);
    do_ack();
    do_ret();

    // Masked source stays pending; unmasking raises it on the second edge.
    wmask(15'h0000);
    pulse(0);
    tick(3);
    check("t3_pending", 32'(pending), 32'h0001);
    check("t3_masked", 32'(interrupt), 0);
    tick(2);
    check("t3_still_masked", 32'(interrupt), 0);
    mask_we   = 1'b1;
    mask_data = 15'h0001;
    tick(1);
    mask_we   = 1'b0;
    check("t3_write_edge", 32'(interrupt), 0);
    tick(1);
    check("t3_unmasked", 32'(interrupt), 1);
    do_ack();
    do_ret();
    wmask(15'h7FFF);

    // Re-raise during SERVICE, and edge colliding with the acknowledge clear.
    pulse(3);
    tick(4);
    check("t4_interrupt", 32'(interrupt), 4);
    do_ack();
    check("t4_cleared", 32'(pending), 0);
    pulse(3);
    tick(3);
    check("t4_repend", 32'(pending), 32'h0008);
    check("t4_svc_int", 32'(interrupt), 4);
    do_ret();
    check("t4_ret_int", 32'(interrupt), 0);
    tick(1);
    check("t4_again", 32'(interrupt), 4);
    pulse(3);
    tick(2);
    do_ack();
    check("t4_set_wins", 32'(pending), 32'h0008);
    check("t4_set_wins_busy", 32'(busy), 1);
    do_ret();
    tick(1);
    check("t4_third", 32'(interrupt), 4);
    do_ack();
    do_ret();
    check("t4_drained", 32'(pending), 0);

    // Out-of-state handshake pulses are ignored.
    do_ack();
    check("t5_idle_ack_int", 32'(interrupt), 0);
    check("t5_idle_ack_busy", 32'(busy), 0);
    tick(2);
    check("t5_idle_quiet", 32'(interrupt), 0);
    pulse(6);
    tick(4);
    check("t5_req", 32'(interrupt), 7);
    do_ret();
    check("t5_req_ret_int", 32'(interrupt), 7);
    check("t5_req_ret_busy", 32'(busy), 0);
    do_ack();
    check("t5_svc", 32'(busy), 1);

    // Asynchronous reset in SERVICE with another source pending.
    pulse(8);
    tick(3);
    check("t6_pre_pending", 32'(pending), 32'h0100);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_int", 32'(interrupt), 0);
    check("t6_rst_pending", 32'(pending), 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    check("t6_after_int", 32'(interrupt), 0);
    check("t6_after_pending", 32'(pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
